pipo_bus_responder: RTL

Register-bank responder on the operand bus driven by the control/data-path initiator. It accepts one request at a time, qualified by a one-hot 3-bit select from the address decoder. It then inserts a fixed number of wait cycles and completes the access with a single-cycle `done` pulse. Three 16-bit PIPO slots hold operands and results written by the initiator and make them available for read-back.

---
 rtl/pipo_bus_pkg.sv | 22 ++
 rtl/resp_reg_bank.sv | 49 ++++
 rtl/pipo_bus_responder.sv | 113 +++++++++++
 3 files changed

// File: rtl/pipo_bus_pkg.sv
// rtl/pipo_bus_pkg.sv - shared FSM type, select encodings and sizes for pipo_bus_responder
package pipo_bus_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W     = 4;

  localparam logic [2:0] SEL_SLOT1 = 3'b001;
  localparam logic [2:0] SEL_SLOT2 = 3'b010;
  localparam logic [2:0] SEL_SLOT3 = 3'b100;
  localparam logic [2:0] SEL_SUM   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_slot_sel(input logic [2:0] sel);
    return (sel == SEL_SLOT1) || (sel == SEL_SLOT2) || (sel == SEL_SLOT3);
  endfunction

endpackage

// File: rtl/resp_reg_bank.sv
// rtl/resp_reg_bank.sv - three PIPO slots with per-slot write and combinational read mux
// Optional sum read path (slot1 + slot2) under PIPO_BUS_RESP_SUM_EN.
module resp_reg_bank
  import pipo_bus_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [2:0]       sel_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_ok_o
);

  logic [WIDTH-1:0] slot1_q, slot2_q, slot3_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot1_q <= '0;
      slot2_q <= '0;
      slot3_q <= '0;
    end else if (wr_en_i) begin
      case (sel_i)
        SEL_SLOT1: slot1_q <= wdata_i;
        SEL_SLOT2: slot2_q <= wdata_i;
        SEL_SLOT3: slot3_q <= wdata_i;
        default: ;
      endcase
    end
  end

  // Unrecognised selects read as zero with rd_ok_o low so the top can flag err.
  always_comb begin
    rd_data_o = '0;
    rd_ok_o   = 1'b0;
    case (sel_i)
      SEL_SLOT1: begin rd_data_o = slot1_q; rd_ok_o = 1'b1; end
      SEL_SLOT2: begin rd_data_o = slot2_q; rd_ok_o = 1'b1; end
      SEL_SLOT3: begin rd_data_o = slot3_q; rd_ok_o = 1'b1; end
`ifdef PIPO_BUS_RESP_SUM_EN
      SEL_SUM:   begin rd_data_o = slot1_q + slot2_q; rd_ok_o = 1'b1; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/pipo_bus_responder.sv
// rtl/pipo_bus_responder.sv - one-at-a-time bus responder with fixed wait states and done/err pulse
// Sum read on sel=111 is enabled by PIPO_BUS_RESP_SUM_EN.
module pipo_bus_responder
  import pipo_bus_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int WAIT  = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [2:0]       sel_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [2:0]       sel_q, sel_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             bank_wr_en;
  logic [WIDTH-1:0] bank_rd_data;
  logic             bank_rd_ok;

  resp_reg_bank #(.WIDTH(WIDTH)) u_bank (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (bank_wr_en),
    .sel_i     (sel_q),
    .wdata_i   (wdata_q),
    .rd_data_o (bank_rd_data),
    .rd_ok_o   (bank_rd_ok)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          sel_d   = sel_i;
          wdata_d = wdata_i;
          cnt_d   = WAIT_CNT;
          state_d = (WAIT_CNT == '0) ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The access itself happens in RESP; its results land in the output registers.
  always_comb begin
    done_d     = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    bank_wr_en = 1'b0;
    if (state_q == ST_RESP) begin
      done_d = 1'b1;
      if (we_q) begin
        if (is_slot_sel(sel_q)) bank_wr_en = 1'b1;
        else                    err_d      = 1'b1;
      end else begin
        rdata_d = bank_rd_data;
        err_d   = !bank_rd_ok;
      end
    end
  end

  assign rdata_o = rdata_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule
